// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, grant pointer type and leading-zero helper for the
// seven-segment scan path.
package display_scan_ctrl_pkg;

    localparam int         DISP_DIGITS = 8;
    localparam logic [7:0] AN_ALL_OFF  = 8'hFF;
    localparam int         BRIGHT_W    = 4;
    localparam int         WORD_W      = 4 * DISP_DIGITS;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

    // Bit i set when nibbles i..top of w are all zero; digit 0 is never flagged.
    function automatic logic [DISP_DIGITS-1:0] lz_mask(input logic [WORD_W-1:0] w);
        logic [DISP_DIGITS-1:0] m;
        logic                   upper_zero;
        m          = '0;
        upper_zero = 1'b1;
        for (int i = DISP_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (w[4*i +: 4] == 4'h0);
            m[i]       = upper_zero;
        end
        return m;
    endfunction

endpackage

// File: rtl/display_arb.sv
// Two-way round-robin write arbiter feeding a one-deep pending word register.
module display_arb
    import display_scan_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [WORD_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [WORD_W-1:0] b_data,
    output logic              b_ready,
    input  logic              commit,
    output logic              pend_full,
    output logic [WORD_W-1:0] pend
);

    gnt_e last_gnt, last_gnt_nxt;

    // The side not granted last wins a tie; nothing is offered while full.
    always_comb begin
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        last_gnt_nxt = last_gnt;
        if (!pend_full) begin
            if (a_valid && (!b_valid || last_gnt == GNT_B)) begin
                a_ready      = 1'b1;
                last_gnt_nxt = GNT_A;
            end else if (b_valid) begin
                b_ready      = 1'b1;
                last_gnt_nxt = GNT_B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= GNT_B;
            pend_full <= 1'b0;
        end else begin
            last_gnt <= last_gnt_nxt;
            if (a_ready || b_ready) begin
                pend_full <= 1'b1;
            end else if (commit) begin
                pend_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_ready) begin
            pend <= a_data;
        end else if (b_ready) begin
            pend <= b_data;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 8-digit seven-segment scan controller: prescaled digit scan, frame-aligned
// commit of arbitrated writes, brightness PWM and leading-zero blanking.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = 15
) (
    input  logic                extclk,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [WORD_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [WORD_W-1:0]   b_data,
    output logic                b_ready,
    input  logic                blank_lz,
    input  logic [BRIGHT_W-1:0] bright,
    output logic [7:0]          an,
    output logic [3:0]          num,
    output logic                frame_start
);

    logic [PRESCALE_W-1:0]  pre;
    logic [2:0]             idx;
    logic [WORD_W-1:0]      shadow;
    logic [WORD_W-1:0]      pend;
    logic                   pend_full;
    logic                   tick;
    logic                   boundary;
    logic                   commit;
    logic                   lit;
    logic [DISP_DIGITS-1:0] blank;

    assign tick     = &pre;
    assign boundary = tick && (idx == 3'(DISP_DIGITS - 1));
    assign commit   = boundary && pend_full;

    display_arb u_arb (
        .clk       (extclk),
        .rst_n     (reset),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .commit    (commit),
        .pend_full (pend_full),
        .pend      (pend)
    );

    // Shadow only changes on the boundary edge so a frame never mixes words.
    always_ff @(posedge extclk or negedge reset) begin
        if (!reset) begin
            pre         <= '0;
            idx         <= '0;
            shadow      <= '0;
            frame_start <= 1'b0;
        end else begin
            pre         <= pre + PRESCALE_W'(1);
            frame_start <= boundary;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            if (commit) begin
                shadow <= pend;
            end
        end
    end

    always_comb begin
        blank = blank_lz ? lz_mask(shadow) : '0;
        lit   = !blank[idx] && (pre[PRESCALE_W-1 -: BRIGHT_W] <= bright);
        an    = lit ? ~(8'b1 << idx) : AN_ALL_OFF;
        num   = shadow[4*idx +: 4];
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl at PRESCALE_W=4 (16 clocks/digit, 128/frame).
module tb_display_scan_ctrl;

    typedef struct {
        logic        side;
        logic [31:0] data;
    } grant_t;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  lit;
    } frame_t;

    logic        clk;
    logic        reset;
    logic        a_valid, b_valid;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        blank_lz;
    logic [3:0]  bright;
    logic [7:0]  an;
    logic [3:0]  num;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int cyc;
    int grants_seen = 0;
    int gcyc[$];
    grant_t grant_q[$];
    frame_t frame_q[$];

    display_scan_ctrl #(.PRESCALE_W(4)) dut (
        .extclk      (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .blank_lz    (blank_lz),
        .bright      (bright),
        .an          (an),
        .num         (num),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc equals the number of clock edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    // Handshake monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (a_valid && b_valid) check("one_ready", {a_ready, b_ready} == 2'b11, 0);
            if ((a_valid && a_ready) || (b_valid && b_ready)) begin
                grant_t g;
                logic   side;
                logic [31:0] d;
                side = (b_valid && b_ready && !(a_valid && a_ready));
                d    = side ? b_data : a_data;
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", {31'd0, side, d}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    g = grant_q.pop_front();
                    check("grant_side", side, g.side);
                    check("grant_data", d, g.data);
                end
                gcyc.push_back(cyc);
                grants_seen++;
            end
        end
    end

    // Frame monitor: samples each digit slot at its first cycle.
    logic [31:0] mon_w;
    logic [63:0] mon_an, mon_exp;
    bit          mon_abort;
    frame_t      mon_f;

    always begin
        @(negedge clk);
        if (reset && frame_start) begin
            check("fs_pos", (cyc % 128 == 0) && (cyc > 0), 1);
            mon_abort = 0;
            mon_w     = '0;
            mon_an    = '0;
            for (int k = 0; k < 8; k++) begin
                mon_w[4*k +: 4]  = num;
                mon_an[8*k +: 8] = an;
                if (k < 7) begin
                    for (int j = 0; j < 16; j++) begin
                        @(negedge clk);
                        if (!reset) mon_abort = 1;
                        if (k == 0 && j == 0 && reset) check("fs_width", frame_start, 0);
                    end
                end
            end
            if (!mon_abort && frame_q.size() > 0) begin
                mon_f = frame_q.pop_front();
                for (int k = 0; k < 8; k++)
                    mon_exp[8*k +: 8] = mon_f.lit[k] ? ~(8'b1 << k) : 8'hFF;
                check("frame_word", mon_w, mon_f.word);
                check("frame_an", mon_an, mon_exp);
            end
        end
    end

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send(input logic side, input logic [31:0] d, output int acc);
        grant_q.push_back('{side: side, data: d});
        if (side) begin b_valid = 1'b1; b_data = d; end
        else      begin a_valid = 1'b1; a_data = d; end
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (side ? b_ready : a_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (side) b_valid = 1'b0;
        else      a_valid = 1'b0;
    endtask

    task automatic count_low(input int bitn, input int start, output int cnt);
        go_to(start);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an[bitn] == 1'b0) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc, cnt, base;
        reset    = 1'b0;
        a_valid  = 1'b1;
        b_valid  = 1'b0;
        a_data   = 32'h0;
        b_data   = 32'h0;
        blank_lz = 1'b0;
        bright   = 4'd15;

        // Reset state and idle scan
        @(negedge clk);
        check("rst_a_ready_follows", a_ready, 1);
        check("rst_an", an, 8'hFE);
        check("rst_num", num, 0);
        check("rst_frame_start", frame_start, 0);
        a_valid = 1'b0;
        #1;
        check("rst_a_ready_low", a_ready, 0);
        frame_q.push_back('{word: 32'h0, lit: 8'hFF});
        release_reset();
        go_to(20);
        @(negedge clk);
        check("scan_idx1_an", an, 8'hFD);

        // Single write mid-frame, then a second word held off until commit
        go_to(168);
        frame_q.push_back('{word: 32'h8765_4321, lit: 8'hFF});
        frame_q.push_back('{word: 32'h1234_5678, lit: 8'hFF});
        send(1'b0, 32'h8765_4321, acc);
        check("single_acc_cyc", acc, 168);
        send(1'b0, 32'h1234_5678, acc);
        check("held_acc_cyc", acc, 256);
        go_to(500);

        // Contention from reset
        assert_reset();
        base = gcyc.size();
        grant_q.push_back('{side: 1'b0, data: 32'hAAAA_AAAA});
        grant_q.push_back('{side: 1'b1, data: 32'hBBBB_BBBB});
        grant_q.push_back('{side: 1'b0, data: 32'hAAAA_AAAA});
        frame_q.push_back('{word: 32'hAAAA_AAAA, lit: 8'hFF});
        frame_q.push_back('{word: 32'hBBBB_BBBB, lit: 8'hFF});
        frame_q.push_back('{word: 32'hAAAA_AAAA, lit: 8'hFF});
        a_valid = 1'b1; a_data = 32'hAAAA_AAAA;
        b_valid = 1'b1; b_data = 32'hBBBB_BBBB;
        release_reset();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (grants_seen >= base + 3) break;
        end
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("contention_grants", gcyc.size() - base, 3);
        if (gcyc.size() >= base + 3) begin
            check("grant0_cyc", gcyc[base], 0);
            check("grant1_cyc", gcyc[base+1], 128);
            check("grant2_cyc", gcyc[base+2], 256);
        end
        go_to(500);

        // Leading-zero blanking and brightness
        assert_reset();
        blank_lz = 1'b1;
        bright   = 4'd15;
        release_reset();
        go_to(20);
        @(negedge clk);
        check("lz_zero_word_idx1_an", an, 8'hFF);
        check("lz_zero_word_num", num, 0);
        go_to(30);
        frame_q.push_back('{word: 32'h0000_0305, lit: 8'h07});
        send(1'b0, 32'h0000_0305, acc);
        check("lz_acc_cyc", acc, 30);
        go_to(250);
        bright = 4'd3;
        count_low(2, 288, cnt);
        check("bright3_lit_cycles", cnt, 4);
        count_low(5, 336, cnt);
        check("blanked_idx5_lit_cycles", cnt, 0);
        go_to(380);
        bright = 4'd0;
        count_low(0, 384, cnt);
        check("bright0_lit_cycles", cnt, 1);
        go_to(400);

        // Reset with a pending word
        assert_reset();
        blank_lz = 1'b0;
        bright   = 4'd15;
        release_reset();
        go_to(10);
        send(1'b0, 32'hDEAD_BEEF, acc);
        check("pre_reset_acc_cyc", acc, 10);
        go_to(50);
        @(negedge clk);
        check("pend_full_before_reset", dut.u_arb.pend_full, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_an", an, 8'hFE);
        check("midrst_num", num, 0);
        frame_q.push_back('{word: 32'h0, lit: 8'hFF});
        frame_q.push_back('{word: 32'h0, lit: 8'hFF});
        release_reset();
        go_to(380);

        check("frame_q_drained", frame_q.size(), 0);
        check("grant_q_drained", grant_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
